// File: rtl/comp2_pkg.sv
// rtl/comp2_pkg.sv - shared defaults, state encoding and helpers for the comp2 arbiter
package comp2_pkg;
  localparam int DEF_W    = 8;
  localparam int DEF_NREQ = 4;

  localparam logic [DEF_W-1:0] MOST_NEG = {1'b1, {(DEF_W-1){1'b0}}};

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction
endpackage

// File: rtl/comp2.sv
// rtl/comp2.sv - W-bit two's-complement negator
module comp2 #(
  parameter int W = comp2_pkg::DEF_W
) (
  input  logic [W-1:0] a,
  output logic [W-1:0] y
);
  assign y = ~a + W'(1);
endmodule

// File: rtl/comp2_arb.sv
// rtl/comp2_arb.sv - round-robin arbiter sharing one comp2 negator
// between NREQ requesters, with a single-entry registered output stage.
module comp2_arb
  import comp2_pkg::*;
#(
  parameter int NREQ = DEF_NREQ,
  parameter int W    = DEF_W,
  parameter int IDW  = clog2(NREQ)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [NREQ*W-1:0] req_data,
  output logic [NREQ-1:0]   req_ready,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [W-1:0]      res_data,
  output logic [IDW-1:0]    res_id,
  output logic              res_ovf
);
  state_t         state_q, state_d;
  logic [IDW-1:0] rr_ptr;
  logic [IDW-1:0] gnt_id;
  logic           any_valid;
  logic           can_issue;
  logic           xfer;
  logic [W-1:0]   opnd;
  logic [W-1:0]   neg;

  // rst_n gating keeps the grant low for the whole reset assertion
  assign can_issue = rst_n && ((state_q == EMPTY) || res_ready);

  always_comb begin
    int j;
    j         = 0;
    gnt_id    = '0;
    any_valid = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      j = int'(rr_ptr) + k;
      if (j >= NREQ) j = j - NREQ;
      if (!any_valid && req_valid[j]) begin
        any_valid = 1'b1;
        gnt_id    = IDW'(j);
      end
    end
  end

  assign xfer      = can_issue && any_valid;
  assign req_ready = xfer ? (NREQ'(1) << gnt_id) : '0;
  assign opnd      = req_data[int'(gnt_id)*W +: W];

  comp2 #(.W(W)) u_comp2 (
    .a (opnd),
    .y (neg)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= EMPTY;
    else        state_q <= state_d;
  end

  // A refill in the same cycle as a drain keeps FULL, giving zero bubble
  always_comb begin
    state_d = state_q;
    if (xfer)                               state_d = FULL;
    else if ((state_q == FULL) && res_ready) state_d = EMPTY;
  end

  assign res_valid = (state_q == FULL);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_data <= '0;
      res_id   <= '0;
      res_ovf  <= 1'b0;
      rr_ptr   <= '0;
    end else if (xfer) begin
      res_data <= neg;
      res_id   <= gnt_id;
      res_ovf  <= (opnd == MOST_NEG);
      rr_ptr   <= (gnt_id == IDW'(NREQ-1)) ? '0 : gnt_id + IDW'(1);
    end
  end
endmodule

// File: tb/tb_comp2_arb.sv
// tb/tb_comp2_arb.sv - scoreboard bench for comp2_arb
`timescale 1ns/1ps
module tb_comp2_arb;
  localparam int N = 4;
  localparam int W = 8;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [N-1:0]   req_valid;
  logic [N*W-1:0] req_data;
  logic [N-1:0]   req_ready;
  logic           res_valid;
  logic           res_ready;
  logic [W-1:0]   res_data;
  logic [1:0]     res_id;
  logic           res_ovf;

  int errors = 0;
  int checks = 0;

  typedef struct {
    int         id;
    logic [7:0] data;
    logic       ovf;
  } exp_t;

  exp_t         sb[$];
  bit           m_full;
  int           m_ptr;
  logic [N-1:0] last_gnt;

  comp2_arb dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_data  (res_data),
    .res_id    (res_id),
    .res_ovf   (res_ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic offer(input int i, input logic [7:0] d);
    req_valid[i] = 1'b1;
    req_data[i*W +: W] = d;
  endtask

  function automatic logic [N-1:0] model_gnt();
    logic [N-1:0] g;
    int j;
    g = '0;
    if (rst_n && (!m_full || res_ready)) begin
      for (int k = 0; k < N; k++) begin
        j = (m_ptr + k) % N;
        if (g == '0 && req_valid[j]) g[j] = 1'b1;
      end
    end
    return g;
  endfunction

  // One clock: check grant/valid before the edge, pop/push the scoreboard
  task automatic step();
    exp_t         e;
    logic [N-1:0] g;
    int           gi;
    logic [7:0]   d;
    logic [8:0]   t;
    @(negedge clk);
    g  = model_gnt();
    gi = 0;
    for (int k = 0; k < N; k++) if (g[k]) gi = k;
    check("req_ready", 32'(req_ready), 32'(g));
    check("res_valid", 32'(res_valid), 32'(m_full));
    if (m_full && res_ready) begin
      check("sb_nonempty", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check("res_id", 32'(res_id), 32'(e.id));
        check("res_data", 32'(res_data), 32'(e.data));
        check("res_ovf", 32'(res_ovf), 32'(e.ovf));
      end
    end
    if (g != '0) begin
      d = req_data[gi*W +: W];
      t = 9'd256 - {1'b0, d};
      e.id   = gi;
      e.data = t[7:0];
      e.ovf  = (d == 8'h80);
      sb.push_back(e);
      m_ptr = (gi + 1) % N;
    end
    m_full   = (g != '0) ? 1'b1 : (res_ready ? 1'b0 : m_full);
    last_gnt = g;
    @(posedge clk);
    #1;
    req_valid = req_valid & ~g;
  endtask

  initial begin
    logic [7:0] bnd_in  [4];
    logic [7:0] bnd_out [4];
    logic       bnd_ovf [4];
    int         gi;
    bnd_in  = '{8'h00, 8'h80, 8'hFF, 8'h7F};
    bnd_out = '{8'h00, 8'h80, 8'h01, 8'h81};
    bnd_ovf = '{1'b0, 1'b1, 1'b0, 1'b0};

    rst_n     = 1'b0;
    req_valid = '1;
    req_data  = '0;
    res_ready = 1'b1;
    m_full    = 1'b0;
    m_ptr     = 0;
    last_gnt  = '0;

    // Reset state
    #12;
    check("rst_res_valid", 32'(res_valid), 32'd0);
    check("rst_res_data", 32'(res_data), 32'd0);
    check("rst_res_id", 32'(res_id), 32'd0);
    check("rst_res_ovf", 32'(res_ovf), 32'd0);
    check("rst_req_ready", 32'(req_ready), 32'd0);
    req_valid = '0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Single request from requester 2
    offer(2, 8'h05);
    #1;
    check("t1_req_ready", 32'(req_ready), 32'h4);
    step();
    check("t1_res_valid", 32'(res_valid), 32'd1);
    check("t1_res_data", 32'(res_data), 32'hFB);
    check("t1_res_id", 32'(res_id), 32'd2);
    check("t1_res_ovf", 32'(res_ovf), 32'd0);
    check("t1_rr_ptr", 32'(dut.rr_ptr), 32'd3);
    step();

    // Boundary operands via requester 0
    for (int k = 0; k < 4; k++) begin
      offer(0, bnd_in[k]);
      step();
      check("bnd_data", 32'(res_data), 32'(bnd_out[k]));
      check("bnd_ovf", 32'(res_ovf), 32'(bnd_ovf[k]));
      step();
    end

    // Fairness: bring pointer to 0, then keep all four valid
    offer(3, 8'h10);
    step();
    for (int i = 0; i < N; i++) offer(i, 8'(8'h20 + i));
    for (int k = 0; k < 8; k++) begin
      step();
      check("fair_grant", 32'(last_gnt), 32'(1 << (k % 4)));
      gi = 0;
      for (int i = 0; i < N; i++) if (last_gnt[i]) gi = i;
      offer(gi, 8'(8'h40 + k));
    end
    req_valid = '0;
    step();
    step();

    // Backpressure with 0xFB held, then refill on the draining edge
    offer(2, 8'h05);
    step();
    res_ready = 1'b0;
    offer(1, 8'h10);
    for (int k = 0; k < 5; k++) begin
      #1;
      check("bp_req_ready", 32'(req_ready), 32'd0);
      check("bp_res_valid", 32'(res_valid), 32'd1);
      check("bp_res_data", 32'(res_data), 32'hFB);
      check("bp_res_id", 32'(res_id), 32'd2);
      step();
    end
    res_ready = 1'b1;
    step();
    check("bp_no_bubble", 32'(res_valid), 32'd1);
    check("bp_new_data", 32'(res_data), 32'hF0);
    check("bp_new_id", 32'(res_id), 32'd1);
    step();

    // Asynchronous reset while FULL
    res_ready = 1'b0;
    offer(3, 8'h33);
    step();
    #1;
    rst_n = 1'b0;
    offer(1, 8'h44);
    offer(3, 8'h66);
    #1;
    check("mid_rst_valid", 32'(res_valid), 32'd0);
    check("mid_rst_data", 32'(res_data), 32'd0);
    check("mid_rst_id", 32'(res_id), 32'd0);
    check("mid_rst_ovf", 32'(res_ovf), 32'd0);
    check("mid_rst_ready", 32'(req_ready), 32'd0);
    sb.delete();
    m_full    = 1'b0;
    m_ptr     = 0;
    res_ready = 1'b1;
    rst_n     = 1'b1;
    #1;
    check("post_rst_grant", 32'(req_ready), 32'h2);
    step();
    step();
    step();

    // Exhaustive operand sweep through rotating requesters
    for (int a = 0; a < 256; a++) begin
      offer(a % N, 8'(a));
      step();
    end
    step();
    step();

    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/comp2_arb.md
# comp2_arb

Round-robin arbiter that shares one 8-bit two's-complement negator (`comp2`) between several requesters. Each requester offers an operand over a valid/ready handshake. The arbiter grants one per cycle, passes the operand through the shared `comp2` instance, and registers the result with the requester ID into a single-entry output stage with its own valid/ready handshake. It sits between the operand sources and any downstream consumer of negated values.

## Interface
Parameters:
- `NREQ`, default 4: number of requesters, 2..8.
- `W`, default 8: operand width; must match `comp2`.
- `IDW`, default 2: ID width; must equal clog2(NREQ).

Ports:
- `clk`, in, 1: single clock, rising edge.
- `rst_n`, in, 1: reset, asynchronous and active-low.
- `req_valid`, in, NREQ: bit i means requester i offers an operand.
- `req_data`, in, NREQ*W: operand for requester i at bits [i*W +: W].
- `req_ready`, out, NREQ: one-hot or zero; the grant.
- `res_valid`, out, 1: output register holds a result.
- `res_ready`, in, 1: consumer accepts the result.
- `res_data`, out, W: negated operand.
- `res_id`, out, IDW: index of the requester that produced the result.
- `res_ovf`, out, 1: operand was the most-negative value, 100…0.

The block uses one clock. Reset is asynchronous and active-low.

## Operation
- Output stage is a 2-state FSM.
  - EMPTY: `res_valid`=0.
  - FULL: `res_valid`=1.
- `can_issue` = EMPTY or (FULL and `res_ready`).
- Grant rule:
  - If `can_issue` and any `req_valid` bit is set, assert `req_ready` for exactly one requester.
  - The chosen requester is the first valid index at or after `rr_ptr`, scanning upward with wrap.
  - Otherwise `req_ready` = 0.
- `req_ready` is combinational from `req_valid`, `rr_ptr`, FSM state and `res_ready`.
- Transfer occurs when `req_valid[g]` and `req_ready[g]` are both 1. On the next clock edge:
  - `res_data` ← `comp2(req_data[g])`, i.e. (~d + 1) mod 2^W.
  - `res_id` ← g.
  - `res_ovf` ← (d == 1 followed by W-1 zeros).
  - FSM → FULL.
  - `rr_ptr` ← (g+1) mod NREQ.
- Drain without refill: if FULL, `res_ready`=1 and no transfer, then FSM → EMPTY. The data, ID and ovf registers hold their values.
- Simultaneous drain and transfer: FSM stays FULL and loads the new result. This gives zero bubble and sustains 1 result/cycle.
- If FULL and `res_ready`=0, then `req_ready`=0 and all output registers hold.
- `rr_ptr` advances only on a transfer.
- Zero operand yields 0 with `res_ovf`=0. 0x80 yields 0x80 with `res_ovf`=1.
- Requester protocol: a requester must not drop `req_valid` or change `req_data` until it is granted. The arbiter does not check this.

Reset values, applied asynchronously when `rst_n`=0:
- FSM = EMPTY, `res_valid`=0.
- `res_data`=0, `res_id`=0, `res_ovf`=0.
- `rr_ptr`=0.
- `req_ready`=0 while in reset.

Reset mid-operation discards any held result. No result is emitted for it after reset releases.

## Timing
- Latency: 1 cycle from the transfer edge to `res_valid`=1.
- Throughput: 1 result/cycle while `res_ready` stays high.
- Fairness: with all NREQ requesters continuously valid, grants rotate 0,1,…,NREQ-1,0. Worst-case wait is NREQ-1 grants.
- Combinational paths:
  - `res_ready` → `req_ready`.
  - `req_valid` → `req_ready`.
  - There is no path from `req_data` to any output.
- Deassertion of `rst_n` is synchronised externally. The block only requires that `rst_n` meets recovery/removal timing at `clk`.

## Structure
- Package `comp2_pkg` holds:
  - `W` and `NREQ` defaults.
  - The `clog2` function for IDW.
  - The FSM state encoding (EMPTY=0, FULL=1).
  - The `MOST_NEG` constant (1 followed by W-1 zeros).
- Sub-modules: instantiate the existing `comp2` unchanged on the muxed operand. Keep the round-robin priority picker inline.

## Test plan
- Reset then single request: requester 2 offers 0x05 → `req_ready`=0100 same cycle. Next cycle `res_valid`=1, `res_data`=0xFB, `res_id`=2, `res_ovf`=0. Afterwards `rr_ptr`=3.
- Boundary operands via requester 0, with `res_ready`=1:
  - 0x00 → 0x00, ovf=0.
  - 0x80 → 0x80, ovf=1.
  - 0xFF → 0x01.
  - 0x7F → 0x81.
- Fairness: all 4 requesters valid continuously with `res_ready`=1 → `res_id` sequence 0,1,2,3,0,1,2,3 and one result every cycle.
- Backpressure: hold `res_ready`=0 with result 0xFB held → `req_ready`=0 and all outputs stable for 5 cycles. Raising `res_ready` with a request pending → the new result loads on that same edge, with no EMPTY cycle.
- Reset mid-operation: assert `rst_n`=0 asynchronously while FULL → `res_valid`, `res_data`, `res_id` and `res_ovf` go to 0 immediately. After release, the first grant goes to the lowest valid index.
- Exhaustive: sweep operands 0..255 through rotating requesters → every `res_data` equals (256-a) mod 256, with ovf only at 0x80.
